qpp_deinterleaver: RTL and testbench

Receive-side counterpart of the turbo-coder interleaver. Accepts a bit-serial stream in QPP-permuted order (c_pi(i), the `outpii` sequence), writes each bit at its natural-order position π(i), and drains the reconstructed block as bytes in natural order once all K bits are in. The block sits between the serial channel/loopback path and the byte-wise code-block sink. It also serves as the round-trip checker for the interleaver.

---
 rtl/qpp_deinterleaver.sv | 173 +++++++++++++++++
 tb/tb_qpp_deinterleaver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpp_deinterleaver.sv
// QPP de-interleaver: writes a permuted bit stream to natural-order positions, then drains bytes MSB-first.
// Optional feature macro DEINT_BYPASS_EN adds a `bypass` input selecting identity write order.
module qpp_deinterleaver #(
    parameter int K_MAX = 6144
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       k_size_6144,
    input  logic       start,
`ifdef DEINT_BYPASS_EN
    input  logic       bypass,
`endif
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       out_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       busy,
    output logic       block_done
);

    localparam int AW = $clog2(K_MAX);
    localparam int NW = AW - 3;

    localparam logic [AW-1:0] K_SMALL    = AW'(1056);
    localparam logic [AW-1:0] G0_SMALL   = AW'(83);
    localparam logic [AW-1:0] STEP_SMALL = AW'(132);
    localparam logic [AW-1:0] K_LARGE    = AW'(6144);
    localparam logic [AW-1:0] G0_LARGE   = AW'(743);
    localparam logic [AW-1:0] STEP_LARGE = AW'(960);

    // State is kept as a named enum register so checkers can bind to state_q.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] pi_q, pi_d;
    logic [AW-1:0] g_q, g_d;
    logic [AW-1:0] step_q, step_d;
    logic [NW-1:0] n_q, n_d;
    logic [K_MAX-1:0] buf_q;
    logic [AW-1:0] wr_addr;

    logic start_acc, bit_acc, last_bit, byte_acc, last_byte;

    // Both operands are already below k, so one conditional subtract is a full reduction.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW-1:0] k);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end
        return s[AW-1:0];
    endfunction

    assign start_acc = (state_q == S_IDLE) && start;
    assign bit_acc   = (state_q == S_FILL) && bit_valid;
    assign last_bit  = bit_acc && (i_q == (k_q - AW'(1)));
    assign byte_acc  = (state_q == S_DRAIN) && out_ready;
    assign last_byte = byte_acc && (n_q == (k_q[AW-1:3] - NW'(1)));

`ifdef DEINT_BYPASS_EN
    logic bypass_q, bypass_d;

    always_comb begin
        bypass_d = bypass_q;
        if (start_acc) begin
            bypass_d = bypass;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    assign wr_addr = bypass_q ? i_q : pi_q;
`else
    assign wr_addr = pi_q;
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_FILL;
            S_FILL:  if (last_bit) state_d = S_DRAIN;
            S_DRAIN: if (last_byte) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        byte_valid = (state_q == S_DRAIN);
        block_done = (state_q == S_DONE);
        byte_out   = 8'h00;
        if (state_q == S_DRAIN) begin
            for (int j = 0; j < 8; j++) begin
                byte_out[7-j] = buf_q[{n_q, 3'b000} + AW'(j)];
            end
        end
    end

    always_comb begin
        k_d    = k_q;
        i_d    = i_q;
        pi_d   = pi_q;
        g_d    = g_q;
        step_d = step_q;
        n_d    = n_q;
        if (start_acc) begin
            k_d    = k_size_6144 ? K_LARGE    : K_SMALL;
            g_d    = k_size_6144 ? G0_LARGE   : G0_SMALL;
            step_d = k_size_6144 ? STEP_LARGE : STEP_SMALL;
            i_d    = '0;
            pi_d   = '0;
            n_d    = '0;
        end else if (bit_acc) begin
            pi_d = mod_add(pi_q, g_q, k_q);
            g_d  = mod_add(g_q, step_q, k_q);
            i_d  = i_q + AW'(1);
        end else if (byte_acc) begin
            n_d = n_q + NW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            k_q    <= '0;
            i_q    <= '0;
            pi_q   <= '0;
            g_q    <= '0;
            step_q <= '0;
            n_q    <= '0;
        end else begin
            k_q    <= k_d;
            i_q    <= i_d;
            pi_q   <= pi_d;
            g_q    <= g_d;
            step_q <= step_d;
            n_q    <= n_d;
        end
    end

    // Buffer is never cleared: every position is rewritten each block since pi is a permutation.
    always_ff @(posedge clock) begin
        if (bit_acc) begin
            buf_q[wr_addr] <= bit_in;
        end
    end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Bench for qpp_deinterleaver: QPP reference model, expected-byte queue, monitor on the falling edge.
module tb_qpp_deinterleaver;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       k_size_6144 = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       busy;
  logic       block_done;
`ifdef DEINT_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];
  bit nat[6144];

  qpp_deinterleaver #(.K_MAX(6144)) dut (
    .clock(clock),
    .rst(rst),
    .k_size_6144(k_size_6144),
    .start(start),
`ifdef DEINT_BYPASS_EN
    .bypass(bypass),
`endif
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .out_ready(out_ready),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .busy(busy),
    .block_done(block_done)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference permutation straight from pi(i) = (f1*i + f2*i^2) mod K.
  function automatic int qpp(input int k, input int i);
    longint f1, f2, r;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    r = (f1 * longint'(i) + f2 * longint'(i) * longint'(i)) % longint'(k);
    return int'(r);
  endfunction

  // out_ready pattern: 0 = always ready, 1 = alternating, 2 = random
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  logic       stall_prev = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clock) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (block_done) done_cnt++;
      if (byte_valid) begin
        if (stall_prev) check("stall_hold", {24'h0, byte_out}, {24'h0, held});
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte actual=%0h required=none at %0t", byte_out, $time);
          end else begin
            check("byte", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
          end
        end
      end
      stall_prev = byte_valid && !out_ready;
      held = byte_out;
    end
  end

  // pat: 0 = single one at permuted i=1, 1 = bytes n mod 256, 2 = random, 3 = 0xA5 bytes
  task automatic run_block(input bit big, input int pat, input bit gaps, input bit noise,
                           input bit byp, input int abort_at);
    int k;
    int d0;
    int budget;
    logic [7:0] b;
    k = big ? 6144 : 1056;
    for (int n = 0; n < k / 8; n++) begin
      case (pat)
        1: b = 8'(n % 256);
        2: b = 8'($urandom_range(0, 255));
        3: b = 8'hA5;
        default: b = 8'h00;
      endcase
      for (int j = 0; j < 8; j++) nat[8*n+j] = b[7-j];
    end
    if (pat == 0) nat[qpp(k, 1)] = 1'b1;
    if (abort_at < 0) begin
      for (int n = 0; n < k / 8; n++) begin
        for (int j = 0; j < 8; j++) b[7-j] = nat[8*n+j];
        exp_q.push_back(b);
      end
    end
    d0 = done_cnt;

    @(posedge clock);
    #1;
    k_size_6144 = big;
`ifdef DEINT_BYPASS_EN
    bypass = byp;
`endif
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    k_size_6144 = ~big;
`ifdef DEINT_BYPASS_EN
    bypass = ~byp;
`endif
    check("busy_after_start", {31'h0, busy}, 32'h1);

    for (int i = 0; i < k; i++) begin
      if (i == abort_at) begin
        #2;
        rst = 1'b0;
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("rst_byte_out", {24'h0, byte_out}, 32'h0);
        bit_valid = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock);
        #1;
        check("idle_after_rst", {31'h0, busy}, 32'h0);
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bit_valid = 1'b0;
          bit_in = 1'($urandom_range(0, 1));
          if (noise) start = 1'($urandom_range(0, 1));
          @(posedge clock);
          #1;
          start = 1'b0;
          check("busy_gap", {31'h0, busy}, 32'h1);
        end
      end
      bit_valid = 1'b1;
      bit_in = byp ? nat[i] : nat[qpp(k, i)];
      @(posedge clock);
      #1;
      if (i % 64 == 0) check("busy_fill", {31'h0, busy}, 32'h1);
    end
    bit_valid = 1'b0;

    budget = 0;
    while (done_cnt == d0 && budget < 20000) begin
      if (noise && (byte_valid || block_done)) start = 1'($urandom_range(0, 1));
      bit_valid = 1'($urandom_range(0, 1));
      bit_in = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      start = 1'b0;
      budget++;
    end
    bit_valid = 1'b0;
    check("block_done_seen", done_cnt, d0 + 1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock);
    check("done_one_cycle", {31'h0, block_done}, 32'h0);
    check("idle_after_done", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_byte_valid", {31'h0, byte_valid}, 32'h0);
    check("reset_block_done", {31'h0, block_done}, 32'h0);
    check("reset_byte_out", {24'h0, byte_out}, 32'h0);
    rst = 1'b1;

    rdy_mode = 0;
    run_block(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_block(1'b1, 1, 1'b0, 1'b0, 1'b0, -1);
    rdy_mode = 1;
    run_block(1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
    rdy_mode = 2;
    run_block(1'b0, 2, 1'b1, 1'b1, 1'b0, -1);
    run_block(1'b0, 1, 1'b1, 1'b1, 1'b0, -1);
    rdy_mode = 0;
    run_block(1'b1, 2, 1'b0, 1'b0, 1'b0, 500);
    run_block(1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
`ifdef DEINT_BYPASS_EN
    run_block(1'b0, 3, 1'b0, 1'b0, 1'b1, -1);
    run_block(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
